// File: rtl/char_pkg.sv
// Shared definitions for the character-ROM glyph path.
//   Code constants for the mapped characters, their char_rom base addresses,
//   the scheduler state encoding and a row bit-reversal helper.
package char_pkg;

  localparam int unsigned CODE_W     = 8;
  localparam int unsigned ROW_W      = 8;
  localparam int unsigned GLYPH_ROWS = 8;
  localparam int unsigned ROM_ADDR_W = 10;
  localparam int unsigned OWNER_W    = 3;

  // Character codes with dedicated glyphs (decimal code values).
  localparam logic [CODE_W-1:0] CH_PLUS = 8'd20;
  localparam logic [CODE_W-1:0] CH_21   = 8'd21;
  localparam logic [CODE_W-1:0] CH_22   = 8'd22;
  localparam logic [CODE_W-1:0] CH_23   = 8'd23;
  localparam logic [CODE_W-1:0] CH_24   = 8'd24;
  localparam logic [CODE_W-1:0] CH_25   = 8'd25;
  localparam logic [CODE_W-1:0] CH_26   = 8'd26;
  localparam logic [CODE_W-1:0] CH_27   = 8'd27;
  localparam logic [CODE_W-1:0] CH_28   = 8'd28;
  localparam logic [CODE_W-1:0] CH_29   = 8'd29;

  // Glyph base addresses in char_rom; every unmapped code shows a space.
  localparam logic [ROM_ADDR_W-1:0] ADDR_SPACE   = 10'o400;
  localparam logic [ROM_ADDR_W-1:0] ADDR_CH_PLUS = 10'o530;
  localparam logic [ROM_ADDR_W-1:0] ADDR_CH_21   = 10'o550;
  localparam logic [ROM_ADDR_W-1:0] ADDR_CH_22   = 10'o520;
  localparam logic [ROM_ADDR_W-1:0] ADDR_CH_23   = 10'o570;
  localparam logic [ROM_ADDR_W-1:0] ADDR_CH_24   = 10'o460;
  localparam logic [ROM_ADDR_W-1:0] ADDR_CH_25   = 10'o410;
  localparam logic [ROM_ADDR_W-1:0] ADDR_CH_26   = 10'o720;
  localparam logic [ROM_ADDR_W-1:0] ADDR_CH_27   = 10'o670;
  localparam logic [ROM_ADDR_W-1:0] ADDR_CH_28   = 10'o700;
  localparam logic [ROM_ADDR_W-1:0] ADDR_CH_29   = 10'o710;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // ROM rows are MSB = leftmost pixel; consumers want LSB = leftmost.
  function automatic logic [ROW_W-1:0] bit_rev8(input logic [ROW_W-1:0] x);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ROW_W; i++) begin
      r[i] = x[ROW_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/char_code_to_addr.sv
// Combinational char code -> char_rom glyph base address decoder.
//   code        in   8       character code
//   base_addr_c out  ADDR_W  base address of the 8-row glyph (space if unmapped)
module char_code_to_addr
  import char_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic [CODE_W-1:0] code,
  output logic [ADDR_W-1:0] base_addr_c
);

  always_comb begin
    base_addr_c = ADDR_W'(ADDR_SPACE);
    case (code)
      CH_PLUS: base_addr_c = ADDR_W'(ADDR_CH_PLUS);
      CH_21:   base_addr_c = ADDR_W'(ADDR_CH_21);
      CH_22:   base_addr_c = ADDR_W'(ADDR_CH_22);
      CH_23:   base_addr_c = ADDR_W'(ADDR_CH_23);
      CH_24:   base_addr_c = ADDR_W'(ADDR_CH_24);
      CH_25:   base_addr_c = ADDR_W'(ADDR_CH_25);
      CH_26:   base_addr_c = ADDR_W'(ADDR_CH_26);
      CH_27:   base_addr_c = ADDR_W'(ADDR_CH_27);
      CH_28:   base_addr_c = ADDR_W'(ADDR_CH_28);
      CH_29:   base_addr_c = ADDR_W'(ADDR_CH_29);
      default: base_addr_c = ADDR_W'(ADDR_SPACE);
    endcase
  end

endmodule

// File: rtl/char_glyph_scheduler.sv
// Time-shares one single-port char_rom between NREQ requesters.
//   Round-robin arbitration, sequential 8-row fetch, row bit-reversal and a
//   valid/ready glyph return.
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   req, req_code  request bits and per-requester 8-bit char codes
//   grant          one-hot accept pulse (combinational, IDLE cycle only)
//   busy           scheduler not in IDLE
//   rom_address    char_rom address; rom_q row data back from char_rom
//   glyph_valid/glyph_ready/glyph_owner/glyph_rows  assembled glyph handshake
module char_glyph_scheduler
  import char_pkg::*;
#(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [8*NREQ-1:0]     req_code,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [ADDR_W-1:0]     rom_address,
  input  logic [ROW_W-1:0]      rom_q,
  output logic                  glyph_valid,
  input  logic                  glyph_ready,
  output logic [OWNER_W-1:0]    glyph_owner,
  output logic [GLYPH_ROWS*ROW_W-1:0] glyph_rows
);

  localparam int unsigned LAST  = ROM_LATENCY - 1;
  localparam int unsigned ROW_CW = 3;

  state_t                        state_q, state_d;
  logic [OWNER_W-1:0]            rr_q, rr_d;
  logic [OWNER_W-1:0]            owner_q, owner_d;
  logic [CODE_W-1:0]             code_q, code_d;
  logic [ROW_CW-1:0]             row_q, row_d;
  logic [GLYPH_ROWS*ROW_W-1:0]   rows_q, rows_d;
  logic [ADDR_W-1:0]             rom_address_q, rom_address_d;
  logic                          busy_q, busy_d;
  logic                          valid_q, valid_d;
  logic                          pipe_v_q [ROM_LATENCY];
  logic                          pipe_v_d [ROM_LATENCY];
  logic [ROW_CW-1:0]             pipe_k_q [ROM_LATENCY];
  logic [ROW_CW-1:0]             pipe_k_d [ROM_LATENCY];

  logic [7:0]                    req_ext;
  logic [OWNER_W-1:0]            cand;
  logic [OWNER_W-1:0]            win_idx;
  logic                          win_found;
  logic [CODE_W-1:0]             win_code;
  logic [ADDR_W-1:0]             base_c;

  assign req_ext = 8'(req);

  // Round-robin pick: first requester at or after rr_q, wrapping mod NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = OWNER_W'((32'(rr_q) + i) % NREQ);
      if (!win_found && req_ext[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_code = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (win_idx == OWNER_W'(j)) begin
        win_code = req_code[8*j +: 8];
      end
    end
  end

  // Grant is a same-cycle acknowledge; masked while reset is asserted.
  always_comb begin
    grant = '0;
    if (state_q == IDLE && win_found && !reset) begin
      grant = NREQ'(1) << win_idx;
    end
  end

  // Decode the code that will be in code_q next cycle so the address can be registered.
  char_code_to_addr #(
    .ADDR_W (ADDR_W)
  ) u_code_to_addr (
    .code        (code_d),
    .base_addr_c (base_c)
  );

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    code_d  = code_q;
    row_d   = row_q;
    rows_d  = rows_q;

    // Row-index pipeline tags each rom_q with the row it belongs to.
    pipe_v_d[0] = (state_q == FETCH);
    pipe_k_d[0] = row_q;
    for (int unsigned s = 1; s < ROM_LATENCY; s++) begin
      pipe_v_d[s] = pipe_v_q[s-1];
      pipe_k_d[s] = pipe_k_q[s-1];
    end

    if (pipe_v_q[LAST]) begin
      rows_d[{pipe_k_q[LAST], 3'b000} +: ROW_W] = bit_rev8(rom_q);
    end

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = FETCH;
          owner_d = win_idx;
          code_d  = win_code;
          row_d   = '0;
        end
      end
      FETCH: begin
        row_d = row_q + ROW_CW'(1);
        if (row_q == ROW_CW'(GLYPH_ROWS - 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_v_q[LAST] && pipe_k_q[LAST] == ROW_CW'(GLYPH_ROWS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (glyph_ready) begin
          state_d = IDLE;
          rr_d    = (owner_q == OWNER_W'(NREQ - 1)) ? '0 : owner_q + OWNER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    rom_address_d = (state_d == FETCH) ? base_c + ADDR_W'(row_d) : ADDR_W'(ADDR_SPACE);
    busy_d        = (state_d != IDLE);
    valid_d       = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_q          <= '0;
      owner_q       <= '0;
      code_q        <= '0;
      row_q         <= '0;
      rows_q        <= '0;
      rom_address_q <= ADDR_W'(ADDR_SPACE);
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      for (int unsigned s = 0; s < ROM_LATENCY; s++) begin
        pipe_v_q[s] <= 1'b0;
        pipe_k_q[s] <= '0;
      end
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      owner_q       <= owner_d;
      code_q        <= code_d;
      row_q         <= row_d;
      rows_q        <= rows_d;
      rom_address_q <= rom_address_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      for (int unsigned s = 0; s < ROM_LATENCY; s++) begin
        pipe_v_q[s] <= pipe_v_d[s];
        pipe_k_q[s] <= pipe_k_d[s];
      end
    end
  end

  assign rom_address = rom_address_q;
  assign busy        = busy_q;
  assign glyph_valid = valid_q;
  assign glyph_owner = owner_q;
  assign glyph_rows  = rows_q;

endmodule
